// File: rtl/reprog_loader_pkg.sv
// Shared definitions for the memory reprogramming engine: frame magic,
// FSM state encoding and the byte-lane helper.
package reprog_loader_pkg;

  localparam logic [7:0] PROG_MAGIC = 8'h5A;

  // Byte lanes for the default 32-bit configuration; use byteLanes() when
  // the word width is a parameter.
  localparam int PROG_DEFAULT_DATA_WIDTH = 32;
  localparam int PROG_BYTE_LANES = PROG_DEFAULT_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR0,
    ST_ADDR1,
    ST_CNT0,
    ST_CNT1,
    ST_DATA,
    ST_CSUM
  } progState_e;

  function automatic int byteLanes(input int dataWidth);
    return dataWidth / 8;
  endfunction

endpackage

// File: rtl/reprog_loader_if.sv
// Byte-stream input, CPU-side port, RAM-side port and status flags of the
// reprogramming engine. The slave view belongs to the engine itself.
interface reprog_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);

  logic [7:0]              progData;
  logic                    progValid;
  logic                    progEn;
  logic [ADDR_WIDTH-1:0]   addrIn;
  logic [DATA_WIDTH-1:0]   dataIn;
  logic [DATA_WIDTH/8-1:0] weIn;
  logic                    enIn;
  logic [ADDR_WIDTH-1:0]   addrOut;
  logic [DATA_WIDTH-1:0]   dataOut;
  logic [DATA_WIDTH/8-1:0] weOut;
  logic                    enOut;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output progData, progValid, progEn, addrIn, dataIn, weIn, enIn,
    input  addrOut, dataOut, weOut, enOut, busy, done, err
  );

  modport slave (
    input  progData, progValid, progEn, addrIn, dataIn, weIn, enIn,
    output addrOut, dataOut, weOut, enOut, busy, done, err
  );

endinterface

// File: rtl/prog_frame_fsm.sv
// Frame parser: walks the header, counts payload words, tracks the running
// checksum and the inter-byte timeout, and flags payload bytes and word ends.
module prog_frame_fsm
  import reprog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LANES      = 4,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  progEn_i,
  input  logic                  valid_i,
  input  logic [7:0]            byte_i,
  output progState_e            state_o,
  output logic                  dataByte_o,
  output logic                  wordDone_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  progState_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           cnt_q;
  logic [7:0]            hdrLo_q;
  logic [7:0]            sum_q;
  logic [LW-1:0]         lane_q;
  logic [TW-1:0]         idle_q;
  logic                  done_q;
  logic                  err_q;

  logic [15:0]           hdrWord;
  logic [7:0]            sum_d;
  logic                  lastLane;

  assign hdrWord    = {byte_i, hdrLo_q};
  assign sum_d      = sum_q + byte_i;
  assign lastLane   = (lane_q == LW'(LANES - 1));
  assign dataByte_o = progEn_i && valid_i && (state_q == ST_DATA);
  assign wordDone_o = dataByte_o && lastLane;
  assign state_o    = state_q;
  assign addr_o     = addr_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

  // Frame state machine; an arriving byte always beats a timeout expiring in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      hdrLo_q <= '0;
      sum_q   <= '0;
      lane_q  <= '0;
      idle_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (!progEn_i) begin
      state_q <= ST_IDLE;
      idle_q  <= '0;
      lane_q  <= '0;
    end else if (state_q == ST_IDLE) begin
      idle_q <= '0;
      if (valid_i && (byte_i == PROG_MAGIC)) begin
        state_q <= ST_ADDR0;
        sum_q   <= '0;
        lane_q  <= '0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end
    end else if (valid_i) begin
      idle_q <= '0;
      sum_q  <= sum_d;
      case (state_q)
        ST_ADDR0: begin
          hdrLo_q <= byte_i;
          state_q <= ST_ADDR1;
        end
        ST_ADDR1: begin
          addr_q  <= ADDR_WIDTH'(hdrWord);
          state_q <= ST_CNT0;
        end
        ST_CNT0: begin
          hdrLo_q <= byte_i;
          state_q <= ST_CNT1;
        end
        ST_CNT1: begin
          cnt_q   <= hdrWord;
          lane_q  <= '0;
          state_q <= (hdrWord == 16'd0) ? ST_CSUM : ST_DATA;
        end
        ST_DATA: begin
          if (lastLane) begin
            lane_q <= '0;
            addr_q <= addr_q + ADDR_WIDTH'(1);
            cnt_q  <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              state_q <= ST_CSUM;
            end
          end else begin
            lane_q <= lane_q + LW'(1);
          end
        end
        ST_CSUM: begin
          if (sum_d == 8'h00) begin
            done_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end else if (idle_q == TW'(TIMEOUT - 1)) begin
      err_q   <= 1'b1;
      state_q <= ST_IDLE;
      idle_q  <= '0;
      lane_q  <= '0;
    end else begin
      idle_q <= idle_q + TW'(1);
    end
  end

endmodule

// File: rtl/reprog_loader.sv
// Memory reprogramming engine: assembles little-endian words from framed
// byte packets and writes them to the RAM port, or passes the CPU port
// straight through when programming mode is off.
module reprog_loader
  import reprog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1000000
) (
  input logic           clk,
  input logic           rst,
  reprog_loader_if.slave bus
);

  localparam int LANES = byteLanes(DATA_WIDTH);

  progState_e            fsmState;
  logic                  dataByte;
  logic                  wordDone;
  logic [ADDR_WIDTH-1:0] fsmAddr;
  logic                  fsmDone;
  logic                  fsmErr;

  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] word_d;
  logic                  wrPulse_q;
  logic [ADDR_WIDTH-1:0] wrAddr_q;
  logic [DATA_WIDTH-1:0] wrData_q;

  prog_frame_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LANES     (LANES),
    .TIMEOUT   (TIMEOUT)
  ) uFsm (
    .clk       (clk),
    .rst       (rst),
    .progEn_i  (bus.progEn),
    .valid_i   (bus.progValid),
    .byte_i    (bus.progData),
    .state_o   (fsmState),
    .dataByte_o(dataByte),
    .wordDone_o(wordDone),
    .addr_o    (fsmAddr),
    .done_o    (fsmDone),
    .err_o     (fsmErr)
  );

  // New bytes enter at the top so the first byte of a word ends up in the low lane
  assign word_d = (word_q >> 8) | (DATA_WIDTH'(bus.progData) << (DATA_WIDTH - 8));

  // Word assembler and one-cycle registered write pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= '0;
      wrPulse_q <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
    end else begin
      wrPulse_q <= wordDone;
      if (dataByte) begin
        word_q <= word_d;
      end
      if (wordDone) begin
        wrAddr_q <= fsmAddr;
        wrData_q <= word_d;
      end
    end
  end

  // RAM port mux: engine writes in programming mode, CPU pass-through otherwise
  always_comb begin
    bus.addrOut = bus.addrIn;
    bus.dataOut = bus.dataIn;
    bus.weOut   = bus.weIn;
    bus.enOut   = bus.enIn;
    if (bus.progEn) begin
      bus.addrOut = wrAddr_q;
      bus.dataOut = wrData_q;
      bus.weOut   = {LANES{wrPulse_q}};
      bus.enOut   = wrPulse_q;
    end
  end

  assign bus.busy = bus.progEn && (fsmState != ST_IDLE);
  assign bus.done = fsmDone;
  assign bus.err  = fsmErr;

endmodule

// File: tb/tb_reprog_loader.sv
// Directed bench for reprog_loader: a 32-bit instance and an 8-bit instance
// share clock and reset; write pulses are logged on the falling edge.
module tb_reprog_loader;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reprog_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) busA ();
  reprog_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8))  busB ();

  reprog_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT(TO)) dutA (
    .clk(clk),
    .rst(rst),
    .bus(busA)
  );

  reprog_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TIMEOUT(TO)) dutB (
    .clk(clk),
    .rst(rst),
    .bus(busB)
  );

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  logic [11:0] wrAddrA[$];
  logic [31:0] wrDataA[$];
  logic [3:0]  wrWeA[$];
  logic [11:0] wrAddrB[$];
  logic [7:0]  wrDataB[$];
  int          wrCycB[$];

  // Cycle counter used to timestamp logged writes
  always @(posedge clk) cyc <= cyc + 1;

  // Log every write pulse seen on either RAM port while in programming mode
  always @(negedge clk) begin
    if (busA.progEn && busA.enOut) begin
      wrAddrA.push_back(busA.addrOut);
      wrDataA.push_back(busA.dataOut);
      wrWeA.push_back(busA.weOut);
    end
    if (busB.progEn && busB.enOut) begin
      wrAddrB.push_back(busB.addrOut);
      wrDataB.push_back(busB.dataOut);
      wrCycB.push_back(cyc);
    end
  end

  // Send n bytes back to back, most significant byte of the vector first
  task automatic applyStimulus(input bit sel, input logic [127:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) begin
        busB.progValid = 1'b1;
        busB.progData  = bytes[8*(n-1-i) +: 8];
      end else begin
        busA.progValid = 1'b1;
        busA.progData  = bytes[8*(n-1-i) +: 8];
      end
      @(posedge clk);
      #2;
    end
    busA.progValid = 1'b0;
    busB.progValid = 1'b0;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Directed scenario sequence
  initial begin
    rst = 1'b1;
    busA.progData = '0; busA.progValid = 1'b0; busA.progEn = 1'b1;
    busA.addrIn = '0; busA.dataIn = '0; busA.weIn = '0; busA.enIn = 1'b0;
    busB.progData = '0; busB.progValid = 1'b0; busB.progEn = 1'b1;
    busB.addrIn = '0; busB.dataIn = '0; busB.weIn = '0; busB.enIn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset busy", busA.busy, 1'b0);
    checkOutput("reset done", busA.done, 1'b0);
    checkOutput("reset err", busA.err, 1'b0);
    checkOutput("reset enOut", busA.enOut, 1'b0);
    checkOutput("reset weOut", busA.weOut, 4'h0);
    checkOutput("reset enOut B", busB.enOut, 1'b0);

    $display("[TB] good 32-bit frame");
    applyStimulus(0, 128'h5A, 1);
    checkOutput("busy after magic", busA.busy, 1'b1);
    applyStimulus(0, 128'h10000200_78563412, 8);
    checkOutput("w0 enOut", busA.enOut, 1'b1);
    checkOutput("w0 weOut", busA.weOut, 4'hF);
    checkOutput("w0 addr", busA.addrOut, 12'h010);
    checkOutput("w0 data", busA.dataOut, 32'h12345678);
    applyStimulus(0, 128'hEF, 1);
    checkOutput("w0 pulse ends", busA.enOut, 1'b0);
    checkOutput("w0 we ends", busA.weOut, 4'h0);
    applyStimulus(0, 128'hBEADDE, 3);
    checkOutput("w1 addr", busA.addrOut, 12'h011);
    checkOutput("w1 data", busA.dataOut, 32'hDEADBEEF);
    applyStimulus(0, 128'hA2, 1);
    checkOutput("good done", busA.done, 1'b1);
    checkOutput("good err", busA.err, 1'b0);
    checkOutput("good busy", busA.busy, 1'b0);
    checkOutput("good write count", wrAddrA.size(), 2);
    checkOutput("good wr1 we", wrWeA[1], 4'hF);
    wrAddrA.delete(); wrDataA.delete(); wrWeA.delete();

    $display("[TB] bad checksum frame");
    applyStimulus(0, 128'h5A_10000200_78563412_EFBEADDE_A3, 14);
    checkOutput("bad err", busA.err, 1'b1);
    checkOutput("bad done", busA.done, 1'b0);
    checkOutput("bad write count", wrAddrA.size(), 2);
    checkOutput("bad wr1 data", wrDataA[1], 32'hDEADBEEF);
    wrAddrA.delete(); wrDataA.delete(); wrWeA.delete();
    applyStimulus(0, 128'h5A, 1);
    checkOutput("magic clears err", busA.err, 1'b0);
    checkOutput("magic keeps done low", busA.done, 1'b0);

    $display("[TB] address wrap frame");
    applyStimulus(0, 128'hFF0F0200_01000000_02000000_ED, 13);
    checkOutput("wrap write count", wrAddrA.size(), 2);
    checkOutput("wrap addr0", wrAddrA[0], 12'hFFF);
    checkOutput("wrap data0", wrDataA[0], 32'h00000001);
    checkOutput("wrap addr1", wrAddrA[1], 12'h000);
    checkOutput("wrap data1", wrDataA[1], 32'h00000002);
    checkOutput("wrap done", busA.done, 1'b1);
    wrAddrA.delete(); wrDataA.delete(); wrWeA.delete();

    $display("[TB] timeout");
    applyStimulus(0, 128'h5A_00000100_AABB, 7);
    repeat (TO - 1) @(posedge clk);
    #2;
    checkOutput("timeout busy before", busA.busy, 1'b1);
    checkOutput("timeout err before", busA.err, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("timeout busy", busA.busy, 1'b0);
    checkOutput("timeout err", busA.err, 1'b1);
    checkOutput("timeout no write", wrAddrA.size(), 0);
    applyStimulus(0, 128'h5A_20000100_44332211_35, 10);
    checkOutput("recover done", busA.done, 1'b1);
    checkOutput("recover err", busA.err, 1'b0);
    checkOutput("recover write count", wrAddrA.size(), 1);
    checkOutput("recover addr", wrAddrA[0], 12'h020);
    checkOutput("recover data", wrDataA[0], 32'h11223344);
    wrAddrA.delete(); wrDataA.delete(); wrWeA.delete();

    $display("[TB] pass-through");
    busA.progEn = 1'b0;
    busA.enIn   = 1'b1;
    busA.weIn   = 4'h3;
    busA.addrIn = 12'h123;
    busA.dataIn = 32'hCAFEF00D;
    #1;
    checkOutput("pt addrOut", busA.addrOut, 12'h123);
    checkOutput("pt dataOut", busA.dataOut, 32'hCAFEF00D);
    checkOutput("pt weOut", busA.weOut, 4'h3);
    checkOutput("pt enOut", busA.enOut, 1'b1);
    applyStimulus(0, 128'h5A_00000100, 5);
    checkOutput("pt busy", busA.busy, 1'b0);
    checkOutput("pt done kept", busA.done, 1'b1);
    busA.progEn = 1'b1;
    busA.enIn   = 1'b0;
    busA.weIn   = 4'h0;
    #1;
    checkOutput("pt re-enable busy", busA.busy, 1'b0);
    checkOutput("pt re-enable enOut", busA.enOut, 1'b0);
    checkOutput("pt re-enable weOut", busA.weOut, 4'h0);

    $display("[TB] 8-bit full-rate frame");
    applyStimulus(1, 128'h5A_40000400_A1B2C3D4_D2, 10);
    checkOutput("dw8 write count", wrAddrB.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("dw8 addr", wrAddrB[i], 12'h040 + 12'(i));
      checkOutput("dw8 data", wrDataB[i], 8'hA1 + 8'(8'h11 * i));
    end
    checkOutput("dw8 consecutive", wrCycB[3] - wrCycB[0], 3);
    checkOutput("dw8 done", busB.done, 1'b1);
    checkOutput("dw8 err", busB.err, 1'b0);

    $display("[TB] reset mid-frame cancels pending write");
    applyStimulus(0, 128'h5A_00000100_112233, 8);
    busA.progValid = 1'b1;
    busA.progData  = 8'h44;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    busA.progValid = 1'b0;
    checkOutput("rst enOut", busA.enOut, 1'b0);
    checkOutput("rst busy", busA.busy, 1'b0);
    checkOutput("rst done", busA.done, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("rst no write", wrAddrA.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reprog_loader.md
# reprog_loader

Parametrised memory-reprogramming engine that sits between a byte-stream source (UART receiver through the CDC FIFO) and one port of a dual-port boot/instruction RAM. While `progEn` is high, it parses framed download packets, assembles little-endian words of any byte-multiple width and writes them through the RAM port. It also verifies a checksum, detects stalled transfers and reports status. While `progEn` is low, the RAM port is a transparent pass-through of the CPU-side signals.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, word-address width of the memory port (2..16).
- `DATA_WIDTH`, 32, memory word width; must be a multiple of 8 (8..64).
- `TIMEOUT`, 1000000, idle clocks allowed between bytes inside a frame before abort (≥2).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: memory-side clock.
- `rst` in 1: synchronous, active-high reset.
- `progData` in 8: received byte.
- `progValid` in 1: `progData` valid this cycle; always consumed, no backpressure.
- `progEn` in 1: programming mode select.
- `addrIn` in ADDR_WIDTH, `dataIn` in DATA_WIDTH, `weIn` in DATA_WIDTH/8, `enIn` in 1: CPU-side port.
- `addrOut` out ADDR_WIDTH, `dataOut` out DATA_WIDTH, `weOut` out DATA_WIDTH/8, `enOut` out 1: RAM port.
- `busy` out 1: frame in progress.
- `done` out 1: sticky; last frame completed with a good checksum.
- `err` out 1: sticky; last frame failed (bad checksum or timeout).

## Operation
- Frame format: magic 0x5A, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then CNT×(DATA_WIDTH/8) payload bytes (LSB first per word), then CSUM.
- Checksum: the 8-bit sum of every byte after the magic byte, including CSUM, must be 0x00.
- The start word address is {ADDR_HI,ADDR_LO}[ADDR_WIDTH-1:0]; upper bits are ignored.
- States are IDLE → ADDR0 → ADDR1 → CNT0 → CNT1 → DATA → CSUM → IDLE. CNT=0 goes from CNT1 directly to CSUM.
- IDLE: non-magic bytes are discarded. A magic byte clears `done`/`err`, clears the sum, and moves to ADDR0.
- DATA: bytes are shifted into a word register. On the last byte of a word, one write is issued and the address increments modulo 2^ADDR_WIDTH (wrap allowed). The remaining count decrements, and the FSM moves to CSUM when it reaches 0.
- Writes are not rolled back on checksum failure; `err` reports it.
- CSUM: sum==0 sets `done`; otherwise sets `err`. Return to IDLE.
- Timeout: in any state ≠ IDLE, an idle counter resets on each `progValid` and counts otherwise. On reaching TIMEOUT, set `err`, return to IDLE, and discard any partial word.
- `progEn` low: the FSM is forced to IDLE next cycle (no `err` set, flags kept), bytes are ignored, and the outputs pass through from `addrIn`/`dataIn`/`weIn`/`enIn` combinationally.
- `progEn` high: `enOut` and `weOut` (all ones) are asserted only in the single write-pulse cycle; otherwise both are 0. CPU inputs are ignored.
- `busy` = (state ≠ IDLE) while `progEn` is high.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `err`=0. Write pulse 0, so `enOut`/`weOut` are 0 in programming mode. Internal address, count, sum, word and timeout registers are 0.
- Write latency: the word's last byte is accepted at edge N; `enOut`/`weOut`/`addrOut`/`dataOut` are registered and valid during cycle N+1 for exactly one cycle.
- Back-to-back bytes on every clock are supported at full rate. With DATA_WIDTH=8, one write is issued per clock.
- `done`/`err` update at the edge that accepts CSUM or reaches timeout.
- If the CSUM byte and the TIMEOUT expiry fall in the same cycle, the byte wins (the counter is reset).
- If `rst` and `progValid` are both high, reset wins. If reset occurs mid-frame, it returns to IDLE, and a write pulse pending for the next cycle is cancelled.
- A magic byte seen in a state other than IDLE is ordinary data/header content.

## Structure
- Shared package: `PROG_MAGIC` (8'h5A), the FSM state enumeration, and the byte-lanes constant `DATA_WIDTH/8`.
- One natural sub-module: `prog_frame_fsm` (header/count/checksum/timeout FSM emitting byte-strobe and word-complete). The top keeps the word assembler and the port mux.

## Test plan
- 32-bit: send 5A 10 00 02 00 | 78 56 34 12 | EF BE AD DE | CSUM → writes 0x12345678@0x010 and 0xDEADBEEF@0x011, `done`=1, `err`=0, `weOut`=4'hF for one cycle each.
- Same frame with CSUM+1 → both writes still occur, `err`=1, `done`=0; the next magic clears both flags.
- Address 0x0FFF, CNT=2 (ADDR_WIDTH=12) → writes to 0xFFF, then 0x000.
- Stop after 2 payload bytes, wait TIMEOUT clocks → `err`=1 and `busy`=0 on cycle TIMEOUT. No write is issued; a following good frame succeeds.
- `progEn`=0 with CPU `enIn`=1, `weIn`=4'h3, `addrIn`=0x123 → the outputs equal the inputs in the same cycle. Bytes 5A… are ignored, and `busy` stays 0.
- DATA_WIDTH=8, bytes on consecutive clocks, CNT=4 → four consecutive single-cycle writes at addresses A..A+3, then `done`=1.
